// File: rtl/video_pkg.sv
// video_pkg -- shared definitions for the video timing generator.
//
// Contents:
//   coord_t      10-bit unsigned raster coordinate (hcount / vcount)
//   phase_t      per-axis phase: ACTIVE -> FP -> SYNC -> BP -> ACTIVE
//   DEF_*        default timing constants (768x256 active raster)
//   next_phase() phase that follows a given one, skipping zero-length
//                porch/sync phases
package video_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // All counter arithmetic is 10-bit, so neither axis may exceed this.
  localparam int COORD_RANGE = 1024;

  localparam int DEF_H_ACTIVE = 768;
  localparam int DEF_H_FP     = 32;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BP     = 160;

  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FP     = 24;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 36;

  // Phase entered when 'cur' ends. Empty phases are skipped; after BP
  // (or when every later phase is empty) the axis wraps to ACTIVE.
  function automatic phase_t next_phase(input phase_t cur, input int fp,
                                        input int sync, input int bp);
    phase_t nxt;
    nxt = PH_ACTIVE;
    case (cur)
      PH_ACTIVE: begin
        if (fp > 0)        nxt = PH_FP;
        else if (sync > 0) nxt = PH_SYNC;
        else if (bp > 0)   nxt = PH_BP;
        else               nxt = PH_ACTIVE;
      end
      PH_FP: begin
        if (sync > 0)      nxt = PH_SYNC;
        else if (bp > 0)   nxt = PH_BP;
        else               nxt = PH_ACTIVE;
      end
      PH_SYNC: begin
        if (bp > 0)        nxt = PH_BP;
        else               nxt = PH_ACTIVE;
      end
      default:             nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// video_axis_cnt -- one raster axis: position counter plus phase FSM.
// Used once for the horizontal axis and once for the vertical axis.
//
// Ports:
//   clk_sys  in   master clock
//   reset    in   synchronous active-high reset (count=0, phase=ACTIVE)
//   ce       in   pixel clock enable
//   wrap_en  in   axis may advance this enable (1 for horizontal, the
//                 horizontal wrap for vertical)
//   count    out  current position, 0..TOTAL-1
//   phase    out  current phase (also serves as the FSM debug view)
//   wrap     out  count is at TOTAL-1; the next step returns to 0
module video_axis_cnt
  import video_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic   clk_sys,
  input  logic   reset,
  input  logic   ce,
  input  logic   wrap_en,
  output coord_t count,
  output phase_t phase,
  output logic   wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL > COORD_RANGE) begin : g_total_too_large
    $error("video_axis_cnt: TOTAL=%0d exceeds 10-bit coordinate range", TOTAL);
  end
  if (ACTIVE < 1) begin : g_no_active
    $error("video_axis_cnt: ACTIVE must be at least 1");
  end

  // Last position of each phase; a phase ends when the counter steps
  // past its last position.
  localparam coord_t END_ACT  = coord_t'(ACTIVE - 1);
  localparam coord_t END_FP   = coord_t'(ACTIVE + FP - 1);
  localparam coord_t END_SYNC = coord_t'(ACTIVE + FP + SYNC - 1);
  localparam coord_t LAST     = coord_t'(TOTAL - 1);

  coord_t count_q;
  phase_t phase_q;
  phase_t phase_d;
  coord_t phase_end;
  logic   step;

  assign step  = ce & wrap_en;
  assign wrap  = (count_q == LAST);
  assign count = count_q;
  assign phase = phase_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      phase_q <= phase_d;
      if (step) count_q <= wrap ? '0 : count_q + 10'd1;
    end
  end

  always_comb begin
    phase_end = LAST;
    phase_d   = phase_q;
    case (phase_q)
      PH_ACTIVE: phase_end = END_ACT;
      PH_FP:     phase_end = END_FP;
      PH_SYNC:   phase_end = END_SYNC;
      default:   phase_end = LAST;
    endcase
    if (step && (count_q == phase_end))
      phase_d = next_phase(phase_q, FP, SYNC, BP);
  end

endmodule

// File: rtl/video_timing.sv
// video_timing -- raster timing generator with registered RGB/sync output.
//
// Ports:
//   clk_sys           in   master clock (only clock)
//   reset             in   synchronous active-high reset
//   ce_pix            in   pixel clock enable; everything advances only here
//   R_in/G_in/B_in    in   core pixel for the current hcount/vcount
//   border_rgb        in   border colour (only with VIDEO_TIMING_BORDER_EN)
//   hcount/vcount     out  current raster position (combinational)
//   pix_req           out  current position is an informative active pixel
//   R/G/B             out  registered pixel, zero while blanking
//   HSync/VSync       out  registered positive sync pulses
//   HBlank/VBlank     out  registered blanking flags
//   line_start        out  same as HBlank; its fall marks the first pixel
//
// Optional feature: define VIDEO_TIMING_BORDER_EN to add BORDER_H/BORDER_V
// and border_rgb; the outer BORDER_H pixels / BORDER_V lines of the active
// area then show border_rgb with pix_req=0 (blanking flags unaffected).
//
// All registered outputs describe the position of the previous enable, so
// they lag hcount/vcount by exactly one ce_pix and are mutually aligned.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
`ifdef VIDEO_TIMING_BORDER_EN
  ,
  parameter int BORDER_H = 0,
  parameter int BORDER_V = 0
`endif
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
`ifdef VIDEO_TIMING_BORDER_EN
  input  logic [23:0] border_rgb,
`endif
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        pix_req,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic        line_start
);

  // VSync is re-evaluated only at the first HSync pixel so its edges line
  // up with HSync rising edges.
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);

  coord_t      h_cnt;
  coord_t      v_cnt;
  phase_t      h_phase;
  phase_t      v_phase;
  logic        h_wrap;
  logic        frame_wrap_unused;
  logic        active;
  logic        in_border;
  logic [23:0] pix_rgb;

  logic [7:0]  r_q, g_q, b_q;
  logic        hsync_q, vsync_q, hblank_q, vblank_q;

  video_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce_pix),
    .wrap_en (1'b1),
    .count   (h_cnt),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  video_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce_pix),
    .wrap_en (h_wrap),
    .count   (v_cnt),
    .phase   (v_phase),
    .wrap    (frame_wrap_unused)
  );

  assign hcount = h_cnt;
  assign vcount = v_cnt;
  assign active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

`ifdef VIDEO_TIMING_BORDER_EN
  assign in_border = (h_cnt < coord_t'(BORDER_H)) ||
                     (h_cnt >= coord_t'(H_ACTIVE - BORDER_H)) ||
                     (v_cnt < coord_t'(BORDER_V)) ||
                     (v_cnt >= coord_t'(V_ACTIVE - BORDER_V));
`else
  assign in_border = 1'b0;
`endif

  assign pix_req = active && !in_border;

  always_comb begin
    pix_rgb = 24'h000000;
    if (active) begin
`ifdef VIDEO_TIMING_BORDER_EN
      if (in_border) pix_rgb = border_rgb;
      else           pix_rgb = {R_in, G_in, B_in};
`else
      pix_rgb = {R_in, G_in, B_in};
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
    end else if (ce_pix) begin
      {r_q, g_q, b_q} <= pix_rgb;
      hsync_q  <= (h_phase == PH_SYNC);
      hblank_q <= (h_phase != PH_ACTIVE);
      vblank_q <= (v_phase != PH_ACTIVE);
      if (h_cnt == H_SYNC_START) vsync_q <= (v_phase == PH_SYNC);
    end
  end

  assign R          = r_q;
  assign G          = g_q;
  assign B          = b_q;
  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign HBlank     = hblank_q;
  assign VBlank     = vblank_q;
  assign line_start = hblank_q;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing -- self-checking bench for video_timing.
// Raster: H 8/2/3/3 (16 total), V 4/1/2/1 (8 total), ce_pix every 4th clk.
// Define VIDEO_TIMING_BORDER_EN to also exercise the border feature.
module tb_video_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
`ifdef VIDEO_TIMING_BORDER_EN
  localparam int BH = 1, BV = 1;
  logic [23:0] border_rgb;
`endif

  logic       clk_sys;
  logic       reset;
  logic       ce_pix;
  logic [7:0] R_in, G_in, B_in;
  logic [9:0] hcount, vcount;
  logic       pix_req;
  logic [7:0] R, G, B;
  logic       HSync, VSync, HBlank, VBlank, line_start;

  video_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
`ifdef VIDEO_TIMING_BORDER_EN
    , .BORDER_H (BH), .BORDER_V (BV)
`endif
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .R_in       (R_in),
    .G_in       (G_in),
    .B_in       (B_in),
`ifdef VIDEO_TIMING_BORDER_EN
    .border_rgb (border_rgb),
`endif
    .hcount     (hcount),
    .vcount     (vcount),
    .pix_req    (pix_req),
    .R          (R),
    .G          (G),
    .B          (B),
    .HSync      (HSync),
    .VSync      (VSync),
    .HBlank     (HBlank),
    .VBlank     (VBlank),
    .line_start (line_start)
  );

  // ---------------- clock ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // ---------------- reference model ----------------
  // Position of the raster plus the expected registered outputs, which
  // describe the position seen at the previous enable.
  int         mh, mv;
  logic       e_hs, e_vs, e_hb, e_vb;
  logic [23:0] e_rgb;
  bit         rand_rgb = 1;

  function automatic bit m_border(input int h, input int v);
`ifdef VIDEO_TIMING_BORDER_EN
    return (h < BH) || (h >= HA - BH) || (v < BV) || (v >= VA - BV);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_active(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0;
    e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1; e_rgb = 24'h0;
  endtask

  task automatic model_enable();
    e_hb = !(mh < HA);
    e_vb = !(mv < VA);
    e_hs = (mh >= HA + HF) && (mh < HA + HF + HS);
    if (mh == HA + HF) e_vs = (mv >= VA + VF) && (mv < VA + VF + VS);
    if (!m_active(mh, mv))   e_rgb = 24'h0;
`ifdef VIDEO_TIMING_BORDER_EN
    else if (m_border(mh, mv)) e_rgb = border_rgb;
`endif
    else                     e_rgb = {R_in, G_in, B_in};
    mh = mh + 1;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clk_sys cycle; inputs change on the falling edge, the model
  // follows the rising edge, outputs are read on the next falling edge.
  task automatic clk_cycle(input logic ce, input logic rst);
    ce_pix = ce;
    reset  = rst;
    @(posedge clk_sys);
    if (rst)     model_reset();
    else if (ce) model_enable();
    @(negedge clk_sys);
  endtask

  task automatic check_all();
    chk("hcount",     hcount,     mh);
    chk("vcount",     vcount,     mv);
    chk("pix_req",    pix_req,    m_active(mh, mv) && !m_border(mh, mv));
    chk("HSync",      HSync,      e_hs);
    chk("VSync",      VSync,      e_vs);
    chk("HBlank",     HBlank,     e_hb);
    chk("VBlank",     VBlank,     e_vb);
    chk("line_start", line_start, e_hb);
    chk("RGB",        {R, G, B},  e_rgb);
  endtask

  task automatic enable_pixel();
    if (rand_rgb) {R_in, G_in, B_in} = 24'($urandom);
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b1, 1'b0);
    check_all();
  endtask

  task automatic do_reset();
    clk_cycle(1'b0, 1'b1);
    clk_cycle(1'b1, 1'b1);
    clk_cycle(1'b0, 1'b1);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_en;
    int exp_h;
    int exp_v;
  } vec_t;
  vec_t vecs[7];

  int hs_rise, vs_rise, hs_high, vs_high, first_hs, second_hs, vs_idx;
  int r_hits, r_bad, frz_bad;
  logic p_hs, p_vs;
  logic [9:0] s_h, s_v;
  logic [23:0] s_rgb;
  logic [4:0] s_flags;

  initial begin
    vecs[0] = '{0,   0,  0};
    vecs[1] = '{1,   1,  0};
    vecs[2] = '{15,  15, 0};
    vecs[3] = '{16,  0,  1};
    vecs[4] = '{17,  1,  1};
    vecs[5] = '{127, 15, 7};
    vecs[6] = '{128, 0,  0};

    reset = 1'b1; ce_pix = 1'b0;
    R_in = 8'h00; G_in = 8'h00; B_in = 8'h00;
`ifdef VIDEO_TIMING_BORDER_EN
    border_rgb = 24'h00FF00;
`endif
    model_reset();
    @(negedge clk_sys);

    // Reset values, held regardless of ce_pix.
    do_reset();
    check_all();
    chk("rst_hblank", HBlank, 1);
    chk("rst_vblank", VBlank, 1);
    chk("rst_rgb",    {R, G, B}, 0);

    // Table: position after N enables from reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].n_en; k++) enable_pixel();
      chk($sformatf("tbl%0d_h", i), hcount, vecs[i].exp_h);
      chk($sformatf("tbl%0d_v", i), vcount, vecs[i].exp_v);
    end

    // Full frame: sync pulse counts, HSync period, VSync placement.
    do_reset();
    hs_rise = 0; vs_rise = 0; hs_high = 0; vs_high = 0;
    first_hs = -1; second_hs = -1; vs_idx = -1;
    p_hs = HSync; p_vs = VSync;
    for (int k = 1; k <= 128; k++) begin
      enable_pixel();
      if (HSync) hs_high++;
      if (VSync) vs_high++;
      if (HSync && !p_hs) begin
        hs_rise++;
        if (first_hs < 0) first_hs = k;
        else if (second_hs < 0) second_hs = k;
      end
      if (VSync && !p_vs) begin
        vs_rise++;
        vs_idx = k;
        chk("vs_with_hs_rise", HSync && !p_hs, 1);
      end
      p_hs = HSync; p_vs = VSync;
    end
    chk("hs_pulses",    hs_rise, 8);
    chk("vs_pulses",    vs_rise, 1);
    chk("hs_high_pix",  hs_high, 8 * HS);
    chk("vs_high_pix",  vs_high, VS * HT);
    chk("hs_first_idx", first_hs, HA + HF + 1);
    chk("hs_period",    second_hs - first_hs, HT);
    chk("vs_rise_idx",  vs_idx, (VA + VF) * HT + HA + HF + 1);
    chk("frame_end_h",  hcount, 0);
    chk("frame_end_v",  vcount, 0);

    // Constant R_in: visible only outside blanking.
    rand_rgb = 0;
    R_in = 8'hA5; G_in = 8'h00; B_in = 8'h00;
    do_reset();
    r_hits = 0; r_bad = 0;
    for (int k = 0; k < 128; k++) begin
      enable_pixel();
      if (R == 8'hA5) r_hits++;
      if ((HBlank || VBlank) && R != 8'h00) r_bad++;
    end
`ifdef VIDEO_TIMING_BORDER_EN
    chk("r_visible", r_hits, 12);
`else
    chk("r_visible", r_hits, HA * VA);
`endif
    chk("r_in_blank", r_bad, 0);
    rand_rgb = 1;

    // ce_pix low for 50 clocks mid-line: everything holds.
    do_reset();
    for (int k = 0; k < 5; k++) enable_pixel();
    s_h = hcount; s_v = vcount; s_rgb = {R, G, B};
    s_flags = {HSync, VSync, HBlank, VBlank, line_start};
    frz_bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (k[0]) {R_in, G_in, B_in} = 24'($urandom);
      clk_cycle(1'b0, 1'b0);
      if (hcount != s_h || vcount != s_v || {R, G, B} != s_rgb ||
          {HSync, VSync, HBlank, VBlank, line_start} != s_flags) frz_bad++;
    end
    chk("freeze_bad", frz_bad, 0);
    chk("freeze_h",   hcount, 5);
    enable_pixel();
    chk("resume_h",   hcount, 6);

    // Reset mid-pulse at (11,5): restart at (0,0), no stretched sync.
    do_reset();
    for (int k = 0; k < 5 * HT + 11; k++) enable_pixel();
    chk("pre_rst_h",  hcount, 11);
    chk("pre_rst_v",  vcount, 5);
    chk("pre_rst_vs", VSync, 1);
    chk("pre_rst_hs", HSync, 1);
    clk_cycle(1'b0, 1'b1);
    clk_cycle(1'b1, 1'b1);
    reset = 1'b0;
    chk("mid_rst_h",  hcount, 0);
    chk("mid_rst_v",  vcount, 0);
    chk("mid_rst_hs", HSync, 0);
    chk("mid_rst_vs", VSync, 0);
    chk("mid_rst_hb", HBlank, 1);
    for (int k = 0; k < 2 * HT; k++) enable_pixel();

`ifdef VIDEO_TIMING_BORDER_EN
    // Border: outer pixels/lines show border_rgb and drop pix_req.
    rand_rgb = 0;
    R_in = 8'h11; G_in = 8'h22; B_in = 8'h33;
    do_reset();
    r_hits = 0; r_bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (m_active(mh, mv) && m_border(mh, mv) && pix_req) r_bad++;
      enable_pixel();
      if (G == 8'hFF) r_hits++;
    end
    chk("border_g_pix", r_hits, 20);
    chk("border_req",   r_bad, 0);
    rand_rgb = 1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
- REQ-001 Parameter H_ACTIVE, default 768, active pixels per line.
- REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 32 / 64 / 160, horizontal front porch / sync / back porch, in pixels.
- REQ-003 Parameter V_ACTIVE, default 256, active lines per frame.
- REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 24 / 4 / 36, vertical front porch / sync / back porch, in lines.
- REQ-005 clk_sys  in  1  master clock, the only clock.
- REQ-006 reset  in  1  synchronous, active-high reset.
- REQ-007 ce_pix  in  1  pixel clock enable; may be held high continuously.
- REQ-008 R_in, G_in, B_in  in  8 each  core pixel for the current hcount/vcount.
- REQ-009 hcount, vcount  out  10 each  current raster position, combinational from the counters.
- REQ-010 pix_req  out  1  high when the current position is inside the active area.
- REQ-011 R, G, B  out  8 each  registered pixel for video_mixer.
- REQ-012 HSync, VSync  out  1  registered, positive sync pulses.
- REQ-013 HBlank, VBlank  out  1  registered blanking flags.
- REQ-014 line_start  out  1  equals HBlank; its fall marks the first informative pixel.

Function
- REQ-015 All counters and registered outputs SHALL change only on clk_sys edges where ce_pix=1; with ce_pix=0 they SHALL hold.
- REQ-016 hcount SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and then wrap to 0.
- REQ-017 vcount SHALL increment on the hcount wrap and wrap to 0 after V_TOTAL-1, in the same enable cycle in which hcount wraps.
- REQ-018 The horizontal FSM SHALL have the states ACTIVE -> HFP -> HSYNC -> HBP -> ACTIVE.
  - Transitions occur at the hcount boundaries H_ACTIVE, +H_FP, +H_SYNC and at the wrap.
  - Zero-length porch states SHALL be skipped.
- REQ-019 The vertical phases SHALL follow the same ordering on vcount.
- REQ-020 pix_req SHALL be 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
- REQ-021 R/G/B, HSync, VSync, HBlank, VBlank and line_start SHALL lag the position by exactly one ce_pix and SHALL be mutually aligned.
- REQ-022 R/G/B SHALL be forced to 0 whenever the registered HBlank or VBlank is 1.
- REQ-023 HSync SHALL be 1 for exactly H_SYNC pixels per line; VSync SHALL be 1 for exactly V_SYNC lines, with its edges coincident with the HSync rising edges.
- REQ-024 Counter and comparison arithmetic SHALL be unsigned 10-bit; H_TOTAL and V_TOTAL above 1024 SHALL be a static elaboration error.

Reset
- REQ-025 While reset=1, regardless of ce_pix:
  - hcount=0, vcount=0, FSM=ACTIVE;
  - R=G=B=0, HSync=0, VSync=0, HBlank=1, VBlank=1, line_start=1.
- REQ-026 Reset asserted mid-frame SHALL restart at (0,0) on the next enabled pixel; no partial sync pulse is stretched.

Configuration
- REQ-027 Macro VIDEO_TIMING_BORDER_EN, when defined:
  - adds parameters BORDER_H (default 0) and BORDER_V (default 0);
  - adds input border_rgb  in  24  border color.
- REQ-028 With VIDEO_TIMING_BORDER_EN defined, the first and last BORDER_H pixels of each active line and the first and last BORDER_V active lines SHALL:
  - output border_rgb;
  - hold pix_req=0;
  - leave HBlank and VBlank unchanged (both stay 0).
- REQ-029 Without VIDEO_TIMING_BORDER_EN, the border_rgb port SHALL be absent and the behaviour SHALL be exactly REQ-015..REQ-026.

Structure
- REQ-030 A shared package video_pkg SHALL hold:
  - the horizontal-phase enum;
  - the 10-bit coordinate typedef;
  - the default timing constants.
- REQ-031 One sub-module, video_axis_cnt, SHALL be instantiated twice (horizontal and vertical). It provides:
  - counter and phase;
  - a wrap-enable input and a wrap output.

Verification
- Bench configuration for all scenarios: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), ce_pix every 4th clk.
- REQ-032 reset, then ce_pix continuous -> HSync high for pixels 10..12, delayed one pixel; a period of 16 enables; VSync high during lines 5..6.
- REQ-033 R_in=8'hA5 constant -> R=8'hA5 only when HBlank=0 and VBlank=0, and 0 elsewhere.
- REQ-034 ce_pix=0 for 50 clocks mid-line -> all outputs frozen; counting resumes at the next hcount value.
- REQ-035 reset pulsed at hcount=11, vcount=5 -> next enable gives (0,0) with HSync=0, VSync=0, HBlank=1.
- REQ-036 Run 128 enables -> hcount and vcount both back at (0,0), with exactly 8 HSync pulses and 1 VSync pulse.
- REQ-037 With VIDEO_TIMING_BORDER_EN defined, BORDER_H=1, BORDER_V=1, border_rgb=24'h00FF00:
  - pixels 0 and 7 of lines 0..3, and all pixels of lines 0 and 3, output G=8'hFF;
  - pix_req=0 on those pixels.
